// File: rtl/rv32i_defs.sv
// rtl/rv32i_defs.sv - RV32I opcode and instruction-format definitions
package rv32i_defs;

    typedef enum logic [6:0] {
        STALL         = 7'b0000000,
        LOAD          = 7'b0000011,
        IMM_OPERATION = 7'b0010011,
        AUIPC         = 7'b0010111,
        STORE         = 7'b0100011,
        REG_OPERATION = 7'b0110011,
        LUI           = 7'b0110111,
        BRANCH        = 7'b1100011,
        JALR          = 7'b1100111,
        JAL           = 7'b1101111
    } opcode_fmt_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE, FMT_BAD
    } instr_fmt_t;

    // Raw 7-bit input so that opcodes outside the enum map cleanly to FMT_BAD.
    function automatic instr_fmt_t opcode_to_fmt(input logic [6:0] op);
        instr_fmt_t fmt;
        fmt = FMT_BAD;
        case (op)
            REG_OPERATION:             fmt = FMT_R;
            IMM_OPERATION, LOAD, JALR: fmt = FMT_I;
            STORE:                     fmt = FMT_S;
            BRANCH:                    fmt = FMT_B;
            LUI, AUIPC:                fmt = FMT_U;
            JAL:                       fmt = FMT_J;
            STALL:                     fmt = FMT_NONE;
            default:                   fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - combinational RV32I field-to-word encoder
module rv32i_instr_encoder
    import rv32i_defs::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (opcode_to_fmt(opcode))
            FMT_R:    word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:    word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:    word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:    word = {imm[31:12], rd, opcode};
            FMT_J:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_NONE: word = 32'h0000_0000;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_program_loader.sv
// rtl/rv32i_program_loader.sv - encodes instruction descriptors and writes them to instruction memory
module rv32i_program_loader
    import rv32i_defs::*;
#(
    parameter int MemDepth  = 256,
    parameter int AddrWidth = $clog2(MemDepth)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    input  logic                 in_last,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [AddrWidth:0]   count
);

    typedef enum logic {ST_IDLE, ST_LOAD} state_t;

    localparam logic [AddrWidth:0] DepthLimit = (AddrWidth + 1)'(MemDepth);

    state_t             state;
    logic [AddrWidth:0] addr_cnt;
    logic [31:0]        enc_word;
    logic               enc_illegal;
    logic               accept;
    logic               overflow;

    rv32i_instr_encoder u_encoder (
        .opcode  (in_opcode),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_LOAD);
    assign accept   = in_valid && in_ready;
    assign overflow = (addr_cnt == DepthLimit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            // Count lags the address counter by one edge; a new start overrides it below.
            if (mem_we) begin
                count <= count + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        addr_cnt <= '0;
                        count    <= '0;
                        err      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (enc_illegal || overflow) begin
                            err <= 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_cnt[AddrWidth-1:0];
                            mem_wdata <= enc_word;
                            addr_cnt  <= addr_cnt + 1'b1;
                        end
                        if (in_last) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_program_loader.sv
// tb/tb_rv32i_program_loader.sv - scoreboard bench for rv32i_program_loader
module tb_rv32i_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready, mem_we, busy, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;

    logic        in_ready4, mem_we4, busy4, done4, err4;
    logic [1:0]  mem_addr4;
    logic [31:0] mem_wdata4;
    logic [2:0]  count4;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   next_addr = 0;
    int   w4 = 0;

    always #5 clk = ~clk;

    rv32i_program_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    rv32i_program_loader #(.MemDepth(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .busy(busy4), .done(done4), .err(err4), .count(count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", mem_wdata, e.data);
                    check("wr_done", 32'(done), 32'(e.last));
                end
            end else if (done) begin
                check("spurious_done", 32'(done), 32'd0);
            end
            if (mem_we4) w4++;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_count"}, 32'(count), 0);
    endtask

    task automatic open_session();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("open_busy", 32'(busy), 1);
        check("open_err", 32'(err), 0);
        check("open_count", 32'(count), 0);
        next_addr = 0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last, input bit writes,
                        input logic [31:0] exp_word);
        int waited;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid  = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        if (writes) begin
            exp_t e;
            e.addr = 8'(next_addr);
            e.data = exp_word;
            e.last = last;
            sb.push_back(e);
            next_addr++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Format coverage: one beat per format, ending on a STALL with in_last.
        open_session();
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,          1'b0, 1, 32'h002081B3);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF,  1'b0, 1, 32'hFFF00093);
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          1'b0, 1, 32'h0020A423);
        send(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC,  1'b0, 1, 32'hFE000EE3);
        send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       1'b0, 1, 32'h001000EF);
        send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5678,  1'b0, 1, 32'h123452B7);
        send(7'b0010111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000,  1'b0, 1, 32'h00001097);
        send(7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0,          1'b0, 1, 32'h00008067);
        send(7'b0000011, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4,          1'b0, 1, 32'h00412283);
        send(7'b0000000, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFF_FFFF, 1'b1, 1, 32'h0000_0000);
        check("a_busy_after_last", 32'(busy), 0);
        @(posedge clk);
        #1;
        check("a_count", 32'(count), 10);
        check("a_err", 32'(err), 0);

        // Three continuous beats; a start during LOAD must not reset the address.
        open_session();
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         1'b0, 1, 32'h002081B3);
        start = 1'b1;
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 1, 32'hFFF00093);
        start = 1'b0;
        send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         1'b1, 1, 32'h0020A423);
        check("b_busy_after_last", 32'(busy), 0);
        check("b_done_with_write", 32'(done & mem_we), 1);
        check("b_last_addr", 32'(mem_addr), 2);
        @(posedge clk);
        #1;
        check("b_count", 32'(count), 3);

        // Unknown opcode mid-stream: dropped, err set, address unchanged.
        open_session();
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         1'b0, 1, 32'h002081B3);
        send(7'h7F,      5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         1'b0, 0, 32'h0);
        send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 1, 32'hFFF00093);
        check("c_err", 32'(err), 1);
        @(posedge clk);
        #1;
        check("c_count", 32'(count), 2);
        check("c_err_sticky", 32'(err), 1);

        // Five beats into the depth-4 instance: four writes and an overflow error.
        open_session();
        w4 = 0;
        for (int k = 1; k <= 5; k++) begin
            logic [31:0] w;
            w = 32'h0000_0013 | (32'(k) << 20) | (32'(k) << 7);
            send(7'b0010011, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), (k == 5), 1, w);
        end
        check("ovf_done4", 32'(done4), 1);
        check("ovf_busy4", 32'(busy4), 0);
        @(posedge clk);
        #1;
        check("ovf_writes4", 32'(w4), 4);
        check("ovf_err4", 32'(err4), 1);
        check("ovf_count4", 32'(count4), 4);
        check("ovf_err_main", 32'(err), 0);
        check("ovf_count_main", 32'(count), 5);

        // Reset the cycle after an accept: the pending write is killed at once.
        open_session();
        send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 0, 32'h0);
        check("r_write_pending", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        check_reset("rst1");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32i_program_loader.md
# rv32i_program_loader

Write-side counterpart of the instruction decode path. Accepts a stream of field-level RV32I instruction descriptors over a valid/ready handshake and encodes each into its 32-bit machine word per format (R/I/S/B/U/J). Writes the words to consecutive instruction-memory addresses. Sits between the testbench or boot source and the core's instruction memory write port, so programs are built from fields rather than pre-assembled hex.

## Interface
- `MemDepth`, 256: instruction memory depth in words.
- `AddrWidth`, `$clog2(MemDepth)`: word-address width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  opens a load session; ignored while `busy`.
- `in_valid`  in  1  descriptor valid.
- `in_ready`  out  1  descriptor accepted when `in_valid && in_ready` at an edge.
- `in_opcode`  in  7  `opcode_fmt_t` value.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3; `in_funct7`  in  7.
- `in_imm`  in  32  immediate as a byte offset or value; bits are sliced per format.
- `in_last`  in  1  marks the final descriptor of the session.
- `mem_we`  out  1; `mem_addr`  out  AddrWidth; `mem_wdata`  out  32  memory write port.
- `busy`  out  1  session open.
- `done`  out  1  one-cycle pulse, concurrent with the last write.
- `err`  out  1  sticky error, cleared by the next accepted `start`.
- `count`  out  AddrWidth+1  words written this session.

## Operation
FSM states and transitions:
- IDLE to LOAD on `start`. The same edge clears the address counter, `count` and `err`.
- LOAD to IDLE on accepting a beat with `in_last`=1.
- `in_ready` = (state == LOAD).

Encoding by opcode:
- REG_OPERATION (R): f7 | rs2 | rs1 | f3 | rd | op.
- IMM_OPERATION, LOAD, JALR (I): imm[11:0] | rs1 | f3 | rd | op.
- STORE (S): imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
- BRANCH (B): imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
- LUI, AUIPC (U): imm[31:12] | rd | op.
- JAL (J): imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
- STALL: encodes to 32'h0000_0000 and is written normally.

Immediates are not range-checked; unused imm bits are ignored, including bit 0 for B and J.

Error handling:
- Unknown opcode: the beat is accepted, nothing is written, `err` is set and the address is unchanged.
- Overflow (address counter == MemDepth): the beat is accepted and dropped, and `err` is set.
- An unknown or overflowing beat with `in_last`=1 still closes the session and pulses `done`.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `done`, `busy`, `err` = 0; `mem_addr`, `mem_wdata`, `count` = 0. Reset acts immediately, including mid-session and with a write pending.
- Latency: a beat accepted at edge N produces the registered `mem_we`/`mem_addr`/`mem_wdata` during cycle N+1, and `count` increments at edge N+1.
- Throughput: one beat per cycle with no bubbles. Back-to-back beats write consecutive addresses.
- `done` is registered alongside the final write. `busy` falls at the edge that accepts the last beat.
- `start` during LOAD has no effect. `start` on the cycle after the last accept is legal; its counter clear does not disturb the write already registered.

## Structure
- Add to `rv32i_defs`:
  - `instr_fmt_t` enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE, FMT_BAD}.
  - A function mapping `opcode_fmt_t` to `instr_fmt_t`.
- Sub-module `rv32i_instr_encoder`: purely combinational, fields in, word plus `illegal` out.
- The top level holds the FSM, address counter, output register and error logic.

## Test plan
- ADD x3,x1,x2 (op 0110011, f3 0, f7 0) → addr 0, 0x002081B3.
- ADDI x1,x0,-1 (imm 0xFFFFFFFF) → 0xFFF00093; SW x2,8(x1) (f3 010) → 0x0020A423.
- BEQ x0,x0,-4 (imm 0xFFFFFFFC) → 0xFE000EE3; JAL x1,2048 → 0x001000EF.
- Three continuous beats, `in_last` on the third → `mem_we` in three consecutive cycles at addr 0,1,2; `done` with the addr-2 write; `count`=3; `busy` low.
- Opcode 0x7F mid-stream → no write, `err`=1, next valid beat lands on the unchanged address. MemDepth=4 with 5 beats → 4 writes, `err`=1.
- `rst` asserted the cycle after an accept → `mem_we` drops immediately and all outputs return to reset values.
